// File: rtl/riscv_mc_controller_hs.sv
// rtl/riscv_mc_controller_hs.sv - multicycle RISC-V control FSM with memory wait-state handshake
// Drives the shared-memory datapath; traps on illegal op/func3 or memory timeout, counts retirements.
module riscv_mc_controller_hs #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MAX_WAIT      = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       immSrc,
    output logic [2:0]       ALUControl,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXER,
        S_EXEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_TRAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_instret;
    logic                r_trap;
    logic [1:0]          r_cause;

    logic                w_done;
    logic                w_mem_state;
    logic                w_timeout;
    logic                w_trap_req;
    logic [1:0]          w_trap_code;
    logic                w_f3_ok;
    logic [2:0]          w_alu_i;
    logic [2:0]          w_alu_r;
    logic                w_br_ok;
    logic                w_taken;

    assign w_done      = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout   = w_mem_state && !w_done && (r_wait == WAIT_W'(MAX_WAIT - 1));

    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_cause;

    // shared ALU decode for EXER/EXEI; only register ops turn add into sub
    always_comb begin
        w_f3_ok = 1'b1;
        w_alu_i = 3'b000;
        case (func3)
            3'b000:  w_alu_i = 3'b000;
            3'b111:  w_alu_i = 3'b010;
            3'b110:  w_alu_i = 3'b011;
            3'b100:  w_alu_i = 3'b100;
            3'b010:  w_alu_i = 3'b101;
            3'b011:  w_alu_i = 3'b110;
            default: w_f3_ok = 1'b0;
        endcase
        w_alu_r = ((func3 == 3'b000) && func7) ? 3'b001 : w_alu_i;
    end

    always_comb begin
        w_br_ok = 1'b1;
        w_taken = 1'b0;
        case (func3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = neg;
            3'b101:  w_taken = ~neg;
            default: w_br_ok = 1'b0;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        PCWrite     = 1'b0;
        adrSrc      = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        regWrite    = 1'b0;
        resultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        immSrc      = 3'b000;
        ALUControl  = 3'b000;
        retire      = 1'b0;
        w_next      = r_state;
        w_trap_req  = 1'b0;
        w_trap_code = 2'b00;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 2'b10;
                IRWrite   = w_done;
                PCWrite   = w_done;
                if (w_done) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXER;
                    OP_ITYPE:          w_next = S_EXEI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
                        w_trap_req  = 1'b1;
                        w_trap_code = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immSrc  = (op == OP_LOAD) ? 3'b000 : 3'b001;
                w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrSrc  = 1'b1;
                if (w_done) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                retire   = w_done;
                if (w_done) w_next = S_FETCH;
            end
            S_EXER, S_EXEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = (r_state == S_EXEI) ? 2'b01 : 2'b00;
                ALUControl = (r_state == S_EXEI) ? w_alu_i : w_alu_r;
                w_next     = S_ALUWB;
                if (!w_f3_ok) begin
                    w_trap_req  = 1'b1;
                    w_trap_code = 2'b10;
                end
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                if (w_br_ok) begin
                    PCWrite = w_taken;
                    retire  = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_trap_req  = 1'b1;
                    w_trap_code = 2'b10;
                end
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JALR2;
                if (func3 != 3'b000) begin
                    w_trap_req  = 1'b1;
                    w_trap_code = 2'b10;
                end
            end
            S_JALR2: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_LUI: begin
                immSrc    = 3'b100;
                resultSrc = 2'b11;
                regWrite  = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_TRAP;
        endcase
        // a timed-out access abandons the instruction without any architectural write
        if (w_timeout) begin
            w_trap_req  = 1'b1;
            w_trap_code = 2'b11;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            regWrite    = 1'b0;
            retire      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            r_wait <= (w_mem_state && !w_done && !w_timeout) ? r_wait + WAIT_W'(1) : '0;
            if (retire) r_instret <= r_instret + CNT_W'(1);
            if (w_trap_req) begin
                r_state <= S_TRAP;
                r_trap  <= 1'b1;
                r_cause <= w_trap_code;
            end else begin
                r_state <= w_next;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller_hs.sv
// tb/tb_riscv_mc_controller_hs.sv - directed bench for the handshake multicycle controller
module tb_riscv_mc_controller_hs;

    logic        clk, rst, rst2;
    logic [6:0]  op, op2;
    logic [2:0]  func3;
    logic        func7, zero, neg, mem_ready, mem_ready2;
    logic        mem_req, PCWrite, adrSrc, memWrite, IRWrite, regWrite, retire, trap;
    logic [1:0]  resultSrc, ALUSrcA, ALUSrcB, trap_cause;
    logic [2:0]  immSrc, ALUControl;
    logic [31:0] instret;
    logic        mem_req2, PCWrite2, adrSrc2, memWrite2, IRWrite2, regWrite2, retire2, trap2;
    logic [1:0]  resultSrc2, ALUSrcA2, ALUSrcB2, trap_cause2;
    logic [2:0]  immSrc2, ALUControl2;
    logic [3:0]  instret2;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;

    // strobes: {mem_req, adrSrc, memWrite, IRWrite, PCWrite, regWrite, retire}
    // selects: {resultSrc, ALUSrcA, ALUSrcB, immSrc, ALUControl}
    logic [6:0]  strb;
    logic [11:0] sel;
    assign strb = {mem_req, adrSrc, memWrite, IRWrite, PCWrite, regWrite, retire};
    assign sel  = {resultSrc, ALUSrcA, ALUSrcB, immSrc, ALUControl};

    riscv_mc_controller_hs u_dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite), .resultSrc(resultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .immSrc(immSrc), .ALUControl(ALUControl),
        .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    riscv_mc_controller_hs #(.MEM_HANDSHAKE(0), .MAX_WAIT(16), .CNT_W(4)) u_w4 (
        .clk(clk), .rst(rst2), .op(op2), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready2), .mem_req(mem_req2), .PCWrite(PCWrite2), .adrSrc(adrSrc2),
        .memWrite(memWrite2), .IRWrite(IRWrite2), .regWrite(regWrite2), .resultSrc(resultSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .immSrc(immSrc2), .ALUControl(ALUControl2),
        .retire(retire2), .instret(instret2), .trap(trap2), .trap_cause(trap_cause2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({strb, sel, instret, trap, trap_cause} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got strb=%b sel=%b instret=%0d trap=%b cause=%b expected all zero",
                     strb, sel, instret, trap, trap_cause);
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({strb, sel} !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got strb=%b sel=%b expected 0", strb, sel);
        end
        tick();
    endtask

    task automatic test_add_sub();
        op = 7'b0110011; func3 = 3'b000; func7 = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if ({strb, sel} !== {7'b1001100, 12'b10_00_10_000_000}) begin
            errors++;
            $display("FAIL fetch: got strb=%b sel=%b expected 1001100 100010000000", strb, sel);
        end
        tick();
        checks++;
        if ({strb, sel} !== {7'b0000000, 12'b00_01_01_010_000}) begin
            errors++;
            $display("FAIL decode: got strb=%b sel=%b expected 0000000 000101010000", strb, sel);
        end
        tick();
        checks++;
        if ({strb, sel} !== {7'b0000000, 12'b00_10_00_000_000}) begin
            errors++;
            $display("FAIL exer_add: got strb=%b sel=%b expected 0000000 001000000000", strb, sel);
        end
        tick();
        checks++;
        if ({strb, sel, instret} !== {7'b0000011, 12'b0, 32'd0}) begin
            errors++;
            $display("FAIL aluwb_add: got strb=%b sel=%b instret=%0d expected 0000011 0 0", strb, sel, instret);
        end
        tick();
        exp_instret++;
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++;
            $display("FAIL instret_add: got %0d expected %0d", instret, exp_instret);
        end
        func7 = 1'b1;
        tick();
        tick();
        checks++;
        if (sel !== 12'b00_10_00_000_001) begin
            errors++;
            $display("FAIL exer_sub: got sel=%b expected 001000000001", sel);
        end
        tick();
        tick();
        func7 = 1'b0;
        exp_instret++;
    endtask

    task automatic test_lw();
        op = 7'b0000011; func3 = 3'b010; mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (sel !== 12'b00_10_01_000_000) begin
            errors++;
            $display("FAIL memadr_load: got sel=%b expected 001001000000", sel);
        end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== 7'b1100000) begin
                errors++;
                $display("FAIL memread_hold_%0d: got strb=%b expected 1100000", i, strb);
            end
            tick();
        end
        checks++;
        if ({strb, sel} !== {7'b0000011, 12'b01_00_00_000_000}) begin
            errors++;
            $display("FAIL memwb: got strb=%b sel=%b expected 0000011 010000000000", strb, sel);
        end
        tick();
        exp_instret++;
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++;
            $display("FAIL instret_lw: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        op = 7'b1100011; func3 = 3'b100; neg = 1'b1; zero = 1'b0;
        tick();
        tick();
        checks++;
        if ({strb, sel} !== {7'b0000101, 12'b00_10_00_000_001}) begin
            errors++;
            $display("FAIL blt_taken: got strb=%b sel=%b expected 0000101 001000000001", strb, sel);
        end
        tick();
        exp_instret++;
        func3 = 3'b101;
        tick();
        tick();
        checks++;
        if (strb !== 7'b0000001) begin
            errors++;
            $display("FAIL bge_not_taken: got strb=%b expected 0000001", strb);
        end
        tick();
        exp_instret++;
        neg = 1'b0;
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++;
            $display("FAIL instret_branch: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_jal_lui();
        op = 7'b1101111; func3 = 3'b000;
        tick();
        tick();
        checks++;
        if ({strb, sel} !== {7'b0000100, 12'b00_01_10_000_000}) begin
            errors++;
            $display("FAIL jal: got strb=%b sel=%b expected 0000100 000110000000", strb, sel);
        end
        tick();
        checks++;
        if (strb !== 7'b0000011) begin
            errors++;
            $display("FAIL jal_aluwb: got strb=%b expected 0000011", strb);
        end
        tick();
        exp_instret++;
        op = 7'b0110111;
        tick();
        tick();
        checks++;
        if ({strb, sel} !== {7'b0000011, 12'b11_00_00_100_000}) begin
            errors++;
            $display("FAIL lui: got strb=%b sel=%b expected 0000011 110000100000", strb, sel);
        end
        tick();
        exp_instret++;
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++;
            $display("FAIL instret_lui: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_sw_timeout();
        op = 7'b0100011; func3 = 3'b010; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        checks++;
        if (sel !== 12'b00_10_01_001_000) begin
            errors++;
            $display("FAIL memadr_store: got sel=%b expected 001001001000", sel);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({strb, trap} !== {7'b1110000, 1'b0}) begin
                errors++;
                $display("FAIL sw_stall_%0d: got strb=%b trap=%b expected 1110000 0", i, strb, trap);
            end
            tick();
        end
        checks++;
        if ({trap, trap_cause, strb, instret} !== {1'b1, 2'b11, 7'b0, 32'(exp_instret)}) begin
            errors++;
            $display("FAIL sw_timeout_trap: got trap=%b cause=%b strb=%b instret=%0d expected 1 11 0 %0d",
                     trap, trap_cause, strb, instret, exp_instret);
        end
        mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({trap, trap_cause, strb} !== {1'b1, 2'b11, 7'b0}) begin
            errors++;
            $display("FAIL trap_sticky: got trap=%b cause=%b strb=%b expected 1 11 0", trap, trap_cause, strb);
        end
    endtask

    task automatic test_reset_clears();
        rst = 1'b0;
        #1;
        checks++;
        if ({trap, trap_cause, instret} !== '0) begin
            errors++;
            $display("FAIL reset_clears: got trap=%b cause=%b instret=%0d expected 0 0 0", trap, trap_cause, instret);
        end
        tick();
        rst = 1'b1;
        exp_instret = 0;
        tick();
    endtask

    task automatic test_illegal_op();
        op = 7'b0000000; mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({trap, trap_cause, strb, instret} !== {1'b1, 2'b01, 7'b0, 32'd0}) begin
            errors++;
            $display("FAIL illegal_op: got trap=%b cause=%b strb=%b instret=%0d expected 1 01 0 0",
                     trap, trap_cause, strb, instret);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_access();
        op = 7'b0100011; func3 = 3'b010; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (strb !== 7'b1110000) begin
            errors++;
            $display("FAIL mid_access_setup: got strb=%b expected 1110000", strb);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, memWrite} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_drop: got mem_req=%b memWrite=%b expected 0 0", mem_req, memWrite);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_wrap_no_handshake();
        rst2 = 1'b1;
        tick();
        checks++;
        if ({mem_req2, IRWrite2, PCWrite2} !== 3'b111) begin
            errors++;
            $display("FAIL nohs_fetch: got mem_req=%b IRWrite=%b PCWrite=%b expected 1 1 1", mem_req2, IRWrite2, PCWrite2);
        end
        for (int n = 1; n <= 16; n++) begin
            tick();
            tick();
            tick();
            checks++;
            if (instret2 !== 4'(n)) begin
                errors++;
                $display("FAIL wrap_instret_%0d: got %0d expected %0d", n, instret2, n % 16);
            end
        end
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        op = 7'b0; op2 = 7'b0110111; func3 = 3'b0; func7 = 1'b0;
        zero = 1'b0; neg = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0;
        test_reset();
        test_add_sub();
        test_lw();
        test_branch();
        test_jal_lui();
        test_sw_timeout();
        test_reset_clears();
        test_illegal_op();
        test_reset_mid_access();
        test_wrap_no_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
